bitty_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the `bitty` core. Owns the program counter, reads 16-bit instruction words from a synchronous program memory, and presents each word to `bitty` on `instruction` with a one-cycle `run` pulse. Waits for `bitty`'s `done` before advancing to the next word, and halts after the last program word.

---
 rtl/bitty_fetch_pkg.sv | 18 +
 rtl/bitty_fetch_pc_register.sv | 29 ++
 rtl/bitty_fetch.sv | 111 +++++++++++
 tb/tb_bitty_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_fetch_pkg.sv
// bitty_fetch_pkg
//   Shared definitions for the bitty instruction fetch stage.
//   - INSTR_WIDTH : instruction word width, shared with the bitty core
//   - state_t     : fetch sequencer states
package bitty_fetch_pkg;

    localparam int unsigned INSTR_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        ISSUE,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/bitty_fetch_pc_register.sv
// pc_register
//   Program counter register for the bitty fetch stage.
//   Ports:
//     clk    in   clock
//     reset  in   asynchronous active-high reset, clears value to 0
//     clear  in   synchronous clear to 0 (takes priority over inc)
//     inc    in   synchronous increment by 1
//     value  out  current counter value
module pc_register #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/bitty_fetch.sv
// bitty_fetch
//   Instruction fetch stage feeding the bitty core. Owns the program counter,
//   reads one word per instruction from a synchronous program memory, issues
//   it to bitty with a one-cycle run pulse and waits for done before moving on.
//   Halts after the word at PROG_LEN-1.
//   Ports:
//     clk          in   clock
//     reset        in   asynchronous active-high reset
//     start        in   begin execution at pc 0 (honoured in IDLE/HALT only)
//     mem_rd_en    out  program memory read strobe
//     mem_addr     out  program memory address (equals pc)
//     mem_data     in   read data, valid one cycle after mem_rd_en
//     instruction  out  registered instruction word to bitty
//     run          out  one-cycle issue pulse to bitty
//     done         in   completion from bitty (observed in EXEC only)
//     pc           out  program counter
//     busy         out  high outside IDLE and HALT
//     halted       out  high in HALT
module bitty_fetch
    import bitty_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned PROG_LEN   = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   run,
    input  logic                   done,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   halted
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);

    state_t state;
    state_t state_next;
    logic   pc_clear;
    logic   pc_inc;

    pc_register #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .clear (pc_clear),
        .inc   (pc_inc),
        .value (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_clear   = 1'b0;
        pc_inc     = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_clear   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH:    state_next = WAIT_MEM;
            WAIT_MEM: state_next = ISSUE;
            ISSUE:    state_next = EXEC;
            EXEC: begin
                if (done) begin
                    // The last word halts without incrementing, so pc never wraps.
                    if (pc == LAST_PC) begin
                        state_next = HALT;
                    end else begin
                        pc_inc     = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Instruction only changes on the WAIT_MEM edge, keeping it stable
    // through the run pulse and the whole EXEC window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= '0;
        end else if (state == WAIT_MEM) begin
            instruction <= mem_data;
        end
    end

    // All strobes decode from the state register only, so they fall
    // immediately on reset and have no path from start/done.
    assign mem_rd_en = (state == FETCH);
    assign run       = (state == ISSUE);
    assign busy      = (state != IDLE) && (state != HALT);
    assign halted    = (state == HALT);
    assign mem_addr  = pc;

endmodule

// File: tb/tb_bitty_fetch.sv
module tb_bitty_fetch;
    import bitty_fetch_pkg::*;

    localparam int AW = 2;
    localparam int PL = 4;

    typedef struct {
        int          pc;
        logic [15:0] ins;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start_s, start_n;
    logic          done, done_m, done_n;
    logic          mem_rd_en, run, busy, halted;
    logic [AW-1:0] mem_addr, pc;
    logic [15:0]   mem_data, instruction;

    logic          start_b, done_b, mem_rd_en_b, run_b, busy_b, halted_b;
    logic [2:0]    mem_addr_b, pc_b;
    logic [15:0]   mem_data_b, instruction_b;

    logic [15:0]   mem   [PL];
    logic [15:0]   mem_b [8];

    int   cyc = 1;      // index of the next rising edge, as seen at a falling edge
    int   checks = 0;
    int   fails = 0;
    int   runs_b = 0;
    int   model_pc = 0;
    int   exp_halt = -1;
    bit   noise_en = 1'b0;
    exp_t exp_q[$];

    assign start = start_s | start_n;
    assign done  = done_m | done_n;

    bitty_fetch #(.ADDR_WIDTH(AW), .PROG_LEN(PL)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .instruction(instruction),
        .run(run), .done(done), .pc(pc), .busy(busy), .halted(halted)
    );

    bitty_fetch #(.ADDR_WIDTH(3), .PROG_LEN(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mem_rd_en(mem_rd_en_b),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .instruction(instruction_b),
        .run(run_b), .done(done_b), .pc(pc_b), .busy(busy_b), .halted(halted_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous program memories: data one cycle after the read strobe.
    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];
    always @(posedge clk) if (mem_rd_en_b) mem_data_b <= mem_b[mem_addr_b];
    always @(negedge clk) if (run_b) runs_b <= runs_b + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every run pulse must match the oldest expectation.
    initial begin
        exp_t e;
        logic halted_q = 1'b0;
        forever begin
            @(negedge clk);
            if (run) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_run: got run at cycle %0d pc %0d, required none", cyc, pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("run_pc", 32'(pc), e.pc);
                    chk("run_instr", 32'(instruction), 32'(e.ins));
                    chk("run_cycle", cyc, e.cyc);
                end
            end
            if (halted && !halted_q) chk("halt_cycle", cyc, exp_halt);
            halted_q = halted;
        end
    end

    // Reference model of bitty plus the program sequencing rule:
    // after done, either halt (last word) or the next word issues 3 cycles later.
    initial begin
        bit          pending = 1'b0;
        int          left = 0;
        logic [15:0] cur = '0;
        done_m = 1'b0;
        forever begin
            @(negedge clk);
            done_m = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else if (run) begin
                cur     = instruction;
                left    = $urandom_range(1, 5);
                pending = 1'b1;
            end else if (pending) begin
                chk("instr_stable", 32'(instruction), 32'(cur));
                left--;
                if (left == 0) begin
                    done_m  = 1'b1;
                    pending = 1'b0;
                    if (model_pc == PL - 1) begin
                        exp_halt = cyc + 1;
                    end else begin
                        model_pc++;
                        exp_q.push_back('{model_pc, mem[model_pc], cyc + 3});
                    end
                end
            end
        end
    end

    // Spurious stimulus: done while fetching, start while busy.
    initial begin
        bit prev_rd = 1'b0;
        done_n  = 1'b0;
        start_n = 1'b0;
        forever begin
            @(negedge clk);
            done_n  = noise_en && (mem_rd_en || prev_rd) && ($urandom_range(0, 1) == 1);
            start_n = noise_en && busy && ($urandom_range(0, 3) == 0);
            prev_rd = mem_rd_en;
        end
    end

    task automatic begin_program();
        for (int i = 0; i < PL; i++) mem[i] = 16'($urandom);
        @(negedge clk);
        start_s  = 1'b1;
        model_pc = 0;
        exp_halt = -1;
        exp_q.push_back('{0, mem[0], cyc + 3});
        @(negedge clk);
        start_s = 1'b0;
        chk("start_rd_en", 32'(mem_rd_en), 1);
        chk("start_pc", 32'(pc), 0);
        chk("start_halted", 32'(halted), 0);
    endtask

    task automatic wait_halt();
        int t = 0;
        while (!halted && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("halt_reached", 32'(halted), 1);
        chk("halt_pc", 32'(pc), PL - 1);
        chk("halt_instr", 32'(instruction), 32'(mem[PL-1]));
        repeat (3) @(negedge clk);
        chk("halt_hold_pc", 32'(pc), PL - 1);
        chk("halt_hold_busy", 32'(busy), 0);
    endtask

    task automatic reset_mid_exec();
        int t = 0;
        begin_program();
        while (!(run && pc == 2) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("reached_pc2", 32'(pc), 2);
        @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        exp_halt = -1;
        #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_instr", 32'(instruction), 0);
        chk("rst_run", 32'(run), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pc", 32'(pc), 0);
        chk("idle_halted", 32'(halted), 0);
    endtask

    task automatic single_word_program();
        int n;
        for (int i = 0; i < 8; i++) mem_b[i] = 16'($urandom);
        mem_b[0] = 16'h1234;
        @(negedge clk);
        start_b = 1'b1;
        n = cyc;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_rd_en", 32'(mem_rd_en_b), 1);
        chk("b_cycle1", cyc, n + 1);
        @(negedge clk);
        chk("b_run_early", 32'(run_b), 0);
        @(negedge clk);
        chk("b_run", 32'(run_b), 1);
        chk("b_instr", 32'(instruction_b), 32'h1234);
        @(negedge clk);
        chk("b_run_off", 32'(run_b), 0);
        done_b = 1'b1;
        @(negedge clk);
        done_b = 1'b0;
        chk("b_halted", 32'(halted_b), 1);
        chk("b_pc", 32'(pc_b), 0);
        repeat (6) @(negedge clk);
        chk("b_run_count", runs_b, 1);
        chk("b_hold_instr", 32'(instruction_b), 32'h1234);
        chk("b_hold_halted", 32'(halted_b), 1);
    endtask

    initial begin
        reset   = 1'b0;
        start_s = 1'b0;
        start_b = 1'b0;
        done_b  = 1'b0;
        for (int i = 0; i < PL; i++) mem[i] = '0;
        #2 reset = 1'b1;
        #1;
        chk("init_pc", 32'(pc), 0);
        chk("init_instr", 32'(instruction), 0);
        chk("init_run", 32'(run), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_halted", 32'(halted), 0);
        chk("init_rd_en", 32'(mem_rd_en), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        noise_en = 1'b1;
        for (int p = 0; p < 6; p++) begin
            begin_program();
            wait_halt();
        end
        reset_mid_exec();
        begin_program();
        wait_halt();
        noise_en = 1'b0;
        single_word_program();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
